switch_port_traffic_gen: RTL and testbench
==========================================

// Module: switch_port_traffic_gen
// PURPOSE
//  Synthesizable per-port packet source for the 4-port switch: drives one switch input port (valid_in/source_in/target_in/data_in/pkt_type_in)
//  with LFSR-generated packets, honouring the port's fifo_full indication.
//  Used for on-chip BIST and as a traffic source in FPGA bring-up.
//  Counts delivered and rejected packets, with rejections weighted by destination count.
// PARAMETERS
//  PORT_ID     0       switch port driven (0..3); fixes source_out and the self-target exclusion
//  DATA_W      8       payload width
//  GAP_W       4       width of gap_cycles input
//  CNT_W       16      width of num_pkts and all statistic counters
//  RETRY       0       1: hold a rejected packet and re-present it; 0: count it dropped and move on
//  SEED        16'hACE1  LFSR reset seed (must be nonzero)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst_n         in   1       synchronous active-low reset
//  start         in   1       1-cycle pulse, accepted only in IDLE
//  num_pkts      in   CNT_W   packets to issue this run, sampled on start; 0 -> go straight to DONE
//  gap_cycles    in   GAP_W   idle cycles between packets, sampled on start
//  fifo_full     in   1       switch port input FIFO full; a packet presented while high is rejected
//  valid_out     out  1       packet present this cycle (to valid_in)
//  source_out    out  4       one-hot 1<<PORT_ID
//  target_out    out  4       destination bitmap, never zero, never includes PORT_ID
//  data_out      out  DATA_W  payload
//  pkt_type_out  out  2       0 unicast (1 target), 1 multicast (2 targets), 2 broadcast (3 targets); 3 never driven
//  busy          out  1       high in GEN/GAP
//  done          out  1       1-cycle pulse when a run completes
//  sent_cnt      out  CNT_W   packets accepted by the switch (saturating)
//  drop_cnt      out  CNT_W   sum of $countones(target_out) over rejected packets (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; valid_out, busy, done, sent_cnt, drop_cnt = 0;
//   source_out = 1<<PORT_ID; target_out, data_out, pkt_type_out = 0; LFSR = SEED.
//  A reset asserted mid-run aborts it; no done pulse.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances once per packet issued.
//   Not advanced on a RETRY re-present.
//  Target: t = lfsr[3:0] & ~(1<<PORT_ID); if t==0 then t = 1<<((PORT_ID+1)%4).
//  Payload: data_out = lfsr[15:16-DATA_W].
//  Type: pkt_type_out derived from $countones(t): 1->0, 2->1, 3->2.
//  FSM:
//   IDLE --start && num_pkts!=0--> GEN.
//   IDLE --start && num_pkts==0--> DONE.
//    start clears sent_cnt/drop_cnt and loads remaining=num_pkts, gap=gap_cycles.
//   GEN: valid_out=1 for exactly one cycle per presentation; fields registered, stable while valid_out=1.
//    Accept (fifo_full=0): sent_cnt+1; remaining-1.
//    Reject (fifo_full=1), RETRY=0: drop_cnt += popcount(target); remaining-1.
//    Reject (fifo_full=1), RETRY=1: same fields re-presented next cycle, no gap, remaining unchanged, drop_cnt unchanged.
//    After a consumed packet: remaining==0 -> DONE; else gap!=0 -> GAP; else GEN again.
//    With gap=0 this gives back-to-back packets.
//   GAP: valid_out=0 for exactly gap cycles, then GEN.
//   DONE: done=1 one cycle, busy=0, -> IDLE. Counters hold until next start.
//  Latency: first valid_out is 1 cycle after start is sampled.
//  start while busy is ignored.
//  Throughput: gap=0, fifo_full=0 -> one packet per cycle.
//  Counters saturate at all-ones; no wrap.
//  fifo_full is sampled only in cycles with valid_out=1; it is ignored otherwise.
// TESTING
//  T1 reset: rst_n=0 2 cycles -> all outputs at reset values; source_out=1<<PORT_ID; done never pulses.
//  T2 PORT_ID=0, num_pkts=5, gap=0, fifo_full=0:
//   valid_out high cycles 1..5 after start; sent_cnt=5, drop_cnt=0; done at cycle 6.
//   Every target_out[0]==0; pkt_type matches popcount.
//  T3 gap=3, num_pkts=3: valid_out pattern 1,0,0,0,1,0,0,0,1 -> done next cycle.
//  T4 RETRY=0, fifo_full held 1, num_pkts=4: sent_cnt=0; drop_cnt = sum of popcounts of the 4 logged targets.
//  T5 RETRY=1, fifo_full=1 for 3 cycles then 0, num_pkts=1:
//   same target/data presented 4 times; sent_cnt=1, drop_cnt=0.
//  T6 num_pkts=0 -> done 1 cycle after start, valid_out never high.
//   start while busy -> ignored.
//   rst_n low mid-run -> IDLE next cycle, counters 0.

Source files
------------

// File: rtl/switch_port_traffic_gen.sv
// LFSR-driven packet source for one input port of the 4-port switch.
// Issues num_pkts packets with a programmable gap, honouring fifo_full, and keeps delivery statistics.
module switch_port_traffic_gen #(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_W   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RETRY   = 0,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              fifo_full,
  output logic              valid_out,
  output logic [3:0]        source_out,
  output logic [3:0]        target_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        pkt_type_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam logic [3:0]  SELF_MASK = 4'(1 << PORT_ID);
  localparam logic [3:0]  ALT_MASK  = 4'(1 << ((PORT_ID + 1) % 4));
  localparam bit          RETRY_EN  = (RETRY != 0);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_GAP, S_DONE} state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [CNT_W-1:0]   remaining;
  logic [GAP_W-1:0]   gap_len;
  logic [GAP_W-1:0]   gap_cnt;

  logic [3:0]         nxt_target_c;
  logic [2:0]         nxt_pc_c;
  logic [1:0]         nxt_type_c;
  logic [DATA_W-1:0]  nxt_data_c;
  logic [15:0]        lfsr_adv_c;
  logic [2:0]         cur_pc_c;
  logic               hold_c;
  logic               last_c;
  logic               issue_c;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Next packet fields derived from the current LFSR value
  always_comb begin
    nxt_target_c = lfsr[3:0] & ~SELF_MASK;
    if (nxt_target_c == 4'd0) nxt_target_c = ALT_MASK;
    nxt_pc_c   = 3'(nxt_target_c[0]) + 3'(nxt_target_c[1]) + 3'(nxt_target_c[2]) + 3'(nxt_target_c[3]);
    nxt_type_c = 2'(nxt_pc_c - 3'd1);
    nxt_data_c = lfsr[15 -: DATA_W];
    lfsr_adv_c = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    cur_pc_c   = 3'(target_out[0]) + 3'(target_out[1]) + 3'(target_out[2]) + 3'(target_out[3]);
  end

  // A rejected packet is held only in retry mode; otherwise every GEN cycle consumes one packet
  always_comb begin
    hold_c  = (state == S_GEN) && fifo_full && RETRY_EN;
    last_c  = (remaining == CNT_W'(1));
    issue_c = 1'b0;
    case (state)
      S_IDLE:  issue_c = start && (num_pkts != '0);
      S_GEN:   issue_c = !hold_c && !last_c && (gap_len == '0);
      S_GAP:   issue_c = (gap_cnt == '0);
      default: issue_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      remaining    <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      valid_out    <= 1'b0;
      source_out   <= SELF_MASK;
      target_out   <= 4'd0;
      data_out     <= '0;
      pkt_type_out <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sent_cnt     <= '0;
      drop_cnt     <= '0;
    end else begin
      source_out <= SELF_MASK;
      done       <= 1'b0;
      valid_out  <= issue_c || hold_c;
      if (issue_c) begin
        target_out   <= nxt_target_c;
        data_out     <= nxt_data_c;
        pkt_type_out <= nxt_type_c;
        lfsr         <= lfsr_adv_c;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            sent_cnt  <= '0;
            drop_cnt  <= '0;
            remaining <= num_pkts;
            gap_len   <= gap_cycles;
            if (num_pkts == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_GEN;
              busy  <= 1'b1;
            end
          end
        end
        S_GEN: begin
          if (!fifo_full) sent_cnt <= sat_add(sent_cnt, 3'd1);
          else if (!RETRY_EN) drop_cnt <= sat_add(drop_cnt, cur_pc_c);
          if (!hold_c) begin
            remaining <= remaining - CNT_W'(1);
            if (last_c) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (gap_len != '0) begin
              state   <= S_GAP;
              gap_cnt <= gap_len - GAP_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_GEN;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_traffic_gen.sv
// Directed bench for switch_port_traffic_gen: drop mode on port 0, retry mode on port 2.
module tb_switch_port_traffic_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CNT_W-1:0]  num_pkts;
  logic [GAP_W-1:0]  gap_cycles;
  logic              start0, start1, ff0, ff1;
  logic              valid0, valid1, busy0, busy1, done0, done1;
  logic [3:0]        src0, src1, tgt0, tgt1;
  logic [DATA_W-1:0] data0, data1;
  logic [1:0]        type0, type1;
  logic [CNT_W-1:0]  sent0, sent1, drop0, drop1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_port_traffic_gen #(.PORT_ID(0), .DATA_W(DATA_W), .GAP_W(GAP_W), .CNT_W(CNT_W), .RETRY(0), .SEED(16'hACE1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .num_pkts(num_pkts), .gap_cycles(gap_cycles), .fifo_full(ff0),
    .valid_out(valid0), .source_out(src0), .target_out(tgt0), .data_out(data0), .pkt_type_out(type0),
    .busy(busy0), .done(done0), .sent_cnt(sent0), .drop_cnt(drop0));

  switch_port_traffic_gen #(.PORT_ID(2), .DATA_W(DATA_W), .GAP_W(GAP_W), .CNT_W(CNT_W), .RETRY(1), .SEED(16'hACE1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_pkts(num_pkts), .gap_cycles(gap_cycles), .fifo_full(ff1),
    .valid_out(valid1), .source_out(src1), .target_out(tgt1), .data_out(data1), .pkt_type_out(type1),
    .busy(busy1), .done(done1), .sent_cnt(sent1), .drop_cnt(drop1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] exp_tgt(input logic [15:0] l, input int port);
    logic [3:0] t;
    t = l[3:0] & ~(4'(1 << port));
    if (t == 4'd0) t = 4'(1 << ((port + 1) % 4));
    return t;
  endfunction

  function automatic logic [1:0] exp_type(input logic [3:0] t);
    return 2'($countones(t) - 1);
  endfunction

  // Checks the packet currently on port 0 against the model
  task automatic chk_pkt0(input string tag, input logic [15:0] l);
    logic [3:0] t;
    t = exp_tgt(l, 0);
    chk({tag, "_valid"}, 32'(valid0), 32'd1);
    chk({tag, "_tgt"},   32'(tgt0),   32'(t));
    chk({tag, "_data"},  32'(data0),  32'(l[15:8]));
    chk({tag, "_type"},  32'(type0),  32'(exp_type(t)));
    chk({tag, "_self"},  32'(tgt0[0]), 32'd0);
  endtask

  logic [15:0] m0, m1;
  int          exp_drop;
  logic [8:0]  pat9;
  logic [6:0]  pat7;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ff0 = 1'b0; ff1 = 1'b0;
    num_pkts = '0; gap_cycles = '0;
    m0 = 16'hACE1; m1 = 16'hACE1;

    // T1 reset values
    step(); step();
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy",  32'(busy0),  32'd0);
    chk("rst_done",  32'(done0),  32'd0);
    chk("rst_sent",  32'(sent0),  32'd0);
    chk("rst_drop",  32'(drop0),  32'd0);
    chk("rst_src0",  32'(src0),   32'h1);
    chk("rst_src1",  32'(src1),   32'h4);
    chk("rst_tgt",   32'(tgt0),   32'h0);
    chk("rst_data",  32'(data0),  32'h0);
    chk("rst_type",  32'(type0),  32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_done", 32'(done0), 32'd0);

    // T2 five back-to-back packets, no backpressure
    num_pkts = 16'd5; gap_cycles = 4'd0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t2_first_data", 32'(data0), 32'hAC);
    chk("t2_first_tgt",  32'(tgt0),  32'h2);
    for (int i = 0; i < 5; i++) begin
      chk_pkt0("t2_pkt", m0);
      chk("t2_busy", 32'(busy0), 32'd1);
      m0 = lfsr_next(m0);
      step();
    end
    chk("t2_done",  32'(done0),  32'd1);
    chk("t2_valid", 32'(valid0), 32'd0);
    chk("t2_busy0", 32'(busy0),  32'd0);
    chk("t2_sent",  32'(sent0),  32'd5);
    chk("t2_drop",  32'(drop0),  32'd0);
    step();
    chk("t2_done_pulse", 32'(done0), 32'd0);

    // T3 gap of three cycles between packets
    num_pkts = 16'd3; gap_cycles = 4'd3; start0 = 1'b1;
    step();
    start0 = 1'b0;
    pat9 = 9'b100010001;
    for (int j = 0; j < 9; j++) begin
      chk("t3_valid", 32'(valid0), 32'(pat9[j]));
      if (pat9[j]) begin
        chk_pkt0("t3_pkt", m0);
        m0 = lfsr_next(m0);
      end
      step();
    end
    chk("t3_done", 32'(done0), 32'd1);
    chk("t3_sent", 32'(sent0), 32'd3);
    step();

    // T4 drop mode with fifo held full
    num_pkts = 16'd4; gap_cycles = 4'd0; ff0 = 1'b1; start0 = 1'b1; exp_drop = 0;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_pkt0("t4_pkt", m0);
      exp_drop += $countones(exp_tgt(m0, 0));
      m0 = lfsr_next(m0);
      step();
    end
    ff0 = 1'b0;
    chk("t4_done", 32'(done0), 32'd1);
    chk("t4_sent", 32'(sent0), 32'd0);
    chk("t4_drop", 32'(drop0), 32'(exp_drop));
    step();

    // T5 retry mode on port 2: three rejections then acceptance
    num_pkts = 16'd1; gap_cycles = 4'd0; ff1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk("t5_valid", 32'(valid1), 32'd1);
      chk("t5_tgt",   32'(tgt1),   32'(exp_tgt(m1, 2)));
      chk("t5_data",  32'(data1),  32'(m1[15:8]));
      chk("t5_type",  32'(type1),  32'(exp_type(exp_tgt(m1, 2))));
      if (r == 3) ff1 = 1'b0;
      step();
    end
    m1 = lfsr_next(m1);
    chk("t5_done",  32'(done1),  32'd1);
    chk("t5_valid0", 32'(valid1), 32'd0);
    chk("t5_sent",  32'(sent1),  32'd1);
    chk("t5_drop",  32'(drop1),  32'd0);
    step();

    // T6 zero-length run
    num_pkts = 16'd0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t6_done",  32'(done0),  32'd1);
    chk("t6_valid", 32'(valid0), 32'd0);
    chk("t6_busy",  32'(busy0),  32'd0);
    chk("t6_drop",  32'(drop0),  32'd0);
    step();
    chk("t6_done_pulse", 32'(done0), 32'd0);
    chk("t6_valid2",     32'(valid0), 32'd0);

    // start pulses while busy are ignored
    num_pkts = 16'd3; gap_cycles = 4'd2; start0 = 1'b1;
    step();
    num_pkts = 16'd0;
    pat7 = 7'b1001001;
    for (int j = 0; j < 7; j++) begin
      chk("busy_valid", 32'(valid0), 32'(pat7[j]));
      chk("busy_done",  32'(done0),  32'd0);
      if (pat7[j]) begin
        chk_pkt0("busy_pkt", m0);
        m0 = lfsr_next(m0);
      end
      start0 = (j < 1);
      step();
    end
    start0 = 1'b0;
    chk("busy_end_done", 32'(done0), 32'd1);
    chk("busy_end_sent", 32'(sent0), 32'd3);
    step();

    // reset in the middle of a run
    num_pkts = 16'd5; gap_cycles = 4'd0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    chk("mid_sent", 32'(sent0), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m0 = 16'hACE1;
    chk("mid_valid", 32'(valid0), 32'd0);
    chk("mid_busy",  32'(busy0),  32'd0);
    chk("mid_sent0", 32'(sent0),  32'd0);
    chk("mid_drop0", 32'(drop0),  32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("mid_no_done", 32'(done0), 32'd0);
      chk("mid_idle",    32'(valid0), 32'd0);
      step();
    end

    // LFSR restarts from the seed after reset
    num_pkts = 16'd1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk_pkt0("post_rst", m0);
    chk("post_rst_data", 32'(data0), 32'hAC);
    step();
    chk("post_rst_done", 32'(done0), 32'd1);
    chk("post_rst_sent", 32'(sent0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
